uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Receive path for the core0 UART peripheral. Oversamples `rx_pin` with a per-bit cycle counter, deserialises 8N1 frames (LSB first, start=0, stop=1), and buffers completed bytes in a small FIFO. The UART AXI register slave consumes these bytes through a valid/ready byte port and exposes them as a readable RX register. It shares the transmitter's baud divisor, so TX and RX run at the same rate.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `SYNC_STAGES`, default 2: number of flip-flops in the `rx_pin` synchroniser; at least 2.

- `S_AXI_ACLK`, in, 1: the single clock.
- `S_AXI_ARESETN`, in, 1: reset, asynchronous and active-low.
- `baud_div`, in, 16: bit period minus 1, in clock cycles (same meaning as the TX baud register; reset value of that register is 0x1B8). Minimum legal value is 3.
- `rx_pin`, in, 1: serial line, asynchronous to the clock; idles high.
- `rx_data`, out, 8: byte at the FIFO head.
- `rx_valid`, out, 1: FIFO is not empty.
- `rx_ready`, in, 1: consumer pop; a byte is popped when `rx_valid && rx_ready`.
- `rx_count`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `rx_busy`, out, 1: receive FSM is not in IDLE.
- `frame_err`, out, 1: sticky; set when a stop bit is sampled as 0.
- `overrun_err`, out, 1: sticky; set when a byte arrives while the FIFO is full.
- `err_clr`, in, 1: clears both sticky error flags.

## Operation
- Synchroniser: the synchroniser flops reset to 1; `rxs` is the synchronised line value.
- Receive FSM states:
  - IDLE: on `rxs`=0 while the previous `rxs`=1 (falling edge), latch `baud_div` into `div_q`, clear the cycle counter, go to START.
  - START: wait `half` cycles, where `half = (div_q+1)>>1`, then sample. If the sample is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no flag set.
  - DATA: every `div_q+1` cycles, shift the sample into bit `bit_cnt` (LSB first). After 8 bits, go to STOP.
  - STOP: after `div_q+1` cycles, sample. If 1, push the byte to the FIFO. If 0, discard the byte and set `frame_err`. Either way return to IDLE.
- A new frame starts only on a fresh falling edge. After a frame error, the line must return high before the next frame is detected.
- `baud_div` changes mid-frame have no effect because `div_q` is latched at the start edge.
- The cycle counter is 16 bits wide and compares with equality, so it never wraps.
- FIFO is a circular buffer with `$clog2(DEPTH)`-bit pointers that wrap modulo DEPTH; `rx_count` ranges 0..DEPTH.
- Push while full:
  - without a pop in the same cycle: byte dropped, `overrun_err` set;
  - with a pop in the same cycle: both happen, count unchanged, no error.
- Pop and push on an empty FIFO in the same cycle: the pop is ignored (`rx_valid` was 0) and the push proceeds.
- Error flags: `err_clr` clears them. If `err_clr` and a set event occur in the same cycle, the set wins.
- Reset mid-frame: FSM returns to IDLE, FIFO empties, the partial byte is lost.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_count`=0, `rx_busy`=0, `frame_err`=0, `overrun_err`=0.
- Synchroniser latency: SYNC_STAGES cycles from `rx_pin` to `rxs`.
- Let T0 be the clock edge at which IDLE detects the start edge.
- Sample points:
  - start sample at T0+half;
  - data bit i (i=0..7) at T0+half+(i+1)(div_q+1);
  - stop bit at T0+half+9(div_q+1).
- `rx_valid` rises on the cycle after the stop sample, with `rx_data` valid in the same cycle. A pop takes effect at that clock edge and the next entry appears on the following cycle.
- `rx_busy` is high from T0+1 until the cycle after the stop sample.
- Flags update one cycle after their triggering event; `err_clr` takes effect on the next edge.

## Structure
- Shared package `uart_pkg` holds:
  - the RX FSM state enum (IDLE/START/DATA/STOP);
  - `BAUD_115200` = 0x1B8;
  - register offsets: REG_STATE 0x0, REG_TX 0x4, REG_BAUD 0x8, and the new REG_RX 0xC (read pops the FIFO) and REG_RXSTAT 0x10 ({count, overrun, frame, valid}).
- One sub-module, `uart_rx_fifo`, is parameterised by DEPTH with a push/pop/full/empty/count interface. The deserialiser FSM stays in the top module.

## Test plan
- Basic byte: `baud_div`=7, drive 0xA5 as 8N1 → stop sampled at T0+76, `rx_valid`=1 at T0+77, `rx_data`=0xA5, `rx_count`=1; pop → `rx_valid`=0.
- Start-bit glitch: `rx_pin` low for 2 cycles, then high → FSM returns to IDLE, `rx_busy` falls, FIFO stays empty, no flags set.
- Framing error: send 0x3C with stop=0 → `frame_err`=1, count unchanged; `err_clr` pulse → flag cleared; next good byte 0x55 is received correctly.
- Overrun: DEPTH=4, send 0x01..0x05 with `rx_ready`=0 → FIFO holds 0x01..0x04, `overrun_err`=1; popping yields 0x01, 0x02, 0x03, 0x04 in order.
- Full FIFO with pop at push: FIFO full, `rx_ready`=1 on the stop-sample cycle of 0x99 → no overrun, `rx_count` stays 4, 0x99 is last out.
- Reset and baud change: assert `S_AXI_ARESETN`=0 mid-DATA → all outputs return to reset values immediately. Change `baud_div` 7→15 mid-frame → current byte still decodes at 8 cycles/bit; the next byte decodes at 16.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: shared definitions for the core0 UART peripheral.
//   - rx_state_e  : receive FSM states
//   - BAUD_115200 : reset value of the baud divisor register
//   - REG_*       : AXI register offsets
package uart_pkg;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    localparam logic [15:0] BAUD_115200 = 16'h01B8;

    localparam logic [4:0] REG_STATE  = 5'h00;
    localparam logic [4:0] REG_TX     = 5'h04;
    localparam logic [4:0] REG_BAUD   = 5'h08;
    localparam logic [4:0] REG_RX     = 5'h0C;  // read pops the RX FIFO
    localparam logic [4:0] REG_RXSTAT = 5'h10;  // {count, overrun, frame, valid}

endpackage

// File: rtl/uart_rx_core_if.sv
`timescale 1ns/1ps
// uart_rx_core_if: received-byte port between the RX core and its consumer.
//   rx_data  : byte at the FIFO head
//   rx_valid : FIFO not empty
//   rx_ready : consumer pop (effective when rx_valid is also high)
//   rx_count : FIFO occupancy, 0..DEPTH
// master = RX core (byte source), slave = register block (byte sink).
interface uart_rx_core_if #(
    parameter int unsigned DEPTH = 4
);
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [$clog2(DEPTH):0] rx_count;

    modport master (output rx_data, output rx_valid, output rx_count, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input rx_count, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: circular byte buffer for received UART data.
//   push/wdata : write one byte (dropped when full unless a pop happens in the same cycle)
//   pop/rdata  : rdata shows the head; pop advances it (ignored when empty)
//   full/empty/count : occupancy status, count ranges 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic                   push,
    input  logic [7:0]             wdata,
    input  logic                   pop,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// uart_rx_core: 8N1 UART receiver with byte FIFO.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   baud_div    : bit period minus 1 in clocks, latched at each start edge
//   rx_pin      : asynchronous serial input, idles high
//   rx_port     : byte source port (data/valid/ready/count)
//   rx_busy     : receive FSM not idle
//   frame_err   : sticky, stop bit sampled low
//   overrun_err : sticky, byte arrived while FIFO full
//   err_clr     : clears both sticky flags (a same-cycle set wins)
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           S_AXI_ACLK,
    input  logic           S_AXI_ARESETN,
    input  logic [15:0]    baud_div,
    input  logic           rx_pin,
    uart_rx_core_if.master rx_port,
    output logic           rx_busy,
    output logic           frame_err,
    output logic           overrun_err,
    input  logic           err_clr
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_prev_q;

    rx_state_e   state_q;
    logic [15:0] div_q, cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        push_q, busy_q, frame_err_q, overrun_err_q;

    logic [16:0] period;
    logic [15:0] half_last;
    logic        fifo_full, fifo_empty, pop;

    // Synchroniser resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) sync_q <= '1;
        else                sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
    end
    assign rxs = sync_q[SYNC_STAGES-1];

    assign period    = {1'b0, div_q} + 17'd1;
    assign half_last = period[16:1] - 16'd1;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= RxIdle;
            rxs_prev_q  <= 1'b1;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxs_prev_q <= rxs;
            push_q     <= 1'b0;
            if (err_clr) frame_err_q <= 1'b0;
            case (state_q)
                RxIdle: begin
                    if (!rxs && rxs_prev_q) begin
                        div_q   <= baud_div;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RxStart;
                    end
                end
                RxStart: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == half_last) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        if (rxs) begin
                            // Line went back high mid start bit: a glitch, not a frame.
                            busy_q  <= 1'b0;
                            state_q <= RxIdle;
                        end else begin
                            state_q <= RxData;
                        end
                    end
                end
                RxData: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == div_q) begin
                        cnt_q              <= '0;
                        shift_q[bit_cnt_q] <= rxs;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= RxStop;
                    end
                end
                RxStop: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == div_q) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= RxIdle;
                        if (rxs) push_q      <= 1'b1;
                        else     frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

    assign pop = rx_port.rx_valid && rx_port.rx_ready;

    // Overrun only when the head is not leaving in the same cycle.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            overrun_err_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            overrun_err_q <= 1'b1;
        end else if (err_clr) begin
            overrun_err_q <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .push         (push_q),
        .wdata        (shift_q),
        .pop          (pop),
        .rdata        (rx_port.rx_data),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (rx_port.rx_count)
    );

    assign rx_port.rx_valid = !fifo_empty;
    assign rx_busy          = busy_q;
    assign frame_err        = frame_err_q;
    assign overrun_err      = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_core: DEPTH=4, SYNC_STAGES=2, 10 ns clock.
module tb_uart_rx_core;
    localparam int unsigned DEPTH = 4;

    logic        S_AXI_ACLK    = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic [15:0] baud_div      = 16'd7;
    logic        rx_pin        = 1'b1;
    logic        err_clr       = 1'b0;
    logic        rx_busy, frame_err, overrun_err;

    int checks   = 0;
    int failures = 0;

    uart_rx_core_if #(.DEPTH(DEPTH)) rx_if ();

    uart_rx_core #(
        .DEPTH      (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .baud_div     (baud_div),
        .rx_pin       (rx_pin),
        .rx_port      (rx_if),
        .rx_busy      (rx_busy),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .err_clr      (err_clr)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic tick();
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // Drives one frame, each bit held for 'period' clocks, then idles high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int period);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_pin = fr[k];
            repeat (period) tick();
        end
        rx_pin = 1'b1;
        repeat (4) tick();
    endtask

    task automatic do_pop();
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
        checks++; if (rx_if.rx_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rx_if.rx_count); end
        checks++; if ({rx_busy, frame_err, overrun_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {rx_busy, frame_err, overrun_err}); end
        #14 S_AXI_ARESETN = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        baud_div = 16'd7;
        for (int k = 0; k < 80; k++) begin
            rx_pin = fr[k/8];
            tick();
            if (k == 77) begin
                checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_before_stop got=%b exp=1", rx_busy); end
            end
            if (k == 78) begin
                checks++; if ({rx_busy, rx_if.rx_valid} !== 2'b00) begin failures++; $display("FAIL basic_after_stop busy_valid got=%b exp=00", {rx_busy, rx_if.rx_valid}); end
            end
            if (k == 79) begin
                checks++; if (rx_if.rx_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", rx_if.rx_valid); end
                checks++; if (rx_if.rx_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", rx_if.rx_data); end
                checks++; if (rx_if.rx_count !== 3'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", rx_if.rx_count); end
            end
        end
        rx_pin = 1'b1;
        do_pop();
        checks++; if ({rx_if.rx_valid, rx_if.rx_count} !== 4'b0_000) begin failures++; $display("FAIL basic_pop valid_count got=%b exp=0000", {rx_if.rx_valid, rx_if.rx_count}); end
        repeat (4) tick();
    endtask

    task automatic test_glitch();
        rx_pin = 1'b0;
        tick();
        tick();
        rx_pin = 1'b1;
        tick();
        tick();
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b exp=1", rx_busy); end
        repeat (5) tick();
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall got=%b exp=0", rx_busy); end
        checks++; if ({rx_if.rx_valid, rx_if.rx_count, frame_err, overrun_err} !== 6'b0) begin failures++; $display("FAIL glitch_state got=%b exp=000000", {rx_if.rx_valid, rx_if.rx_count, frame_err, overrun_err}); end
        repeat (4) tick();
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 8);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
        checks++; if (rx_if.rx_count !== 3'd0) begin failures++; $display("FAIL ferr_count got=%0d exp=0", rx_if.rx_count); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
        send_frame(8'h55, 1'b1, 8);
        checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'h55}) begin failures++; $display("FAIL ferr_next valid_data got=%h exp=155", {rx_if.rx_valid, rx_if.rx_data}); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_next_flag got=%b exp=0", frame_err); end
        do_pop();
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 8);
        checks++; if (rx_if.rx_count !== 3'd4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", rx_if.rx_count); end
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (rx_if.rx_data !== 8'(i)) begin failures++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, rx_if.rx_data, 8'(i)); end
            do_pop();
        end
        checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", rx_if.rx_valid); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun_err); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [4];
        int n;
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h99};
        send_frame(8'h11, 1'b1, 8);
        send_frame(8'h22, 1'b1, 8);
        send_frame(8'h33, 1'b1, 8);
        send_frame(8'h44, 1'b1, 8);
        checks++; if (rx_if.rx_count !== 3'd4) begin failures++; $display("FAIL full_fill got=%0d exp=4", rx_if.rx_count); end
        n = 0;
        fork
            send_frame(8'h99, 1'b1, 8);
            begin
                while (rx_busy !== 1'b1 && n < 200) begin tick(); n++; end
                while (rx_busy !== 1'b0 && n < 400) begin tick(); n++; end
                rx_if.rx_ready = 1'b1;
                tick();
                rx_if.rx_ready = 1'b0;
            end
        join
        checks++; if (n >= 200) begin failures++; $display("FAIL full_wait_busy got=timeout exp=busy_pulse"); end
        checks++; if (rx_if.rx_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", rx_if.rx_count); end
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL full_no_overrun got=%b exp=0", overrun_err); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_if.rx_data !== exp_q[i]) begin failures++; $display("FAIL full_pop%0d got=%h exp=%h", i, rx_if.rx_data, exp_q[i]); end
            do_pop();
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h12, 1'b1, 8);
        checks++; if ({rx_if.rx_count, rx_if.rx_data} !== {3'd1, 8'h12}) begin failures++; $display("FAIL rst_pre got=%h exp=112", {rx_if.rx_count, rx_if.rx_data}); end
        fork
            send_frame(8'hF0, 1'b1, 8);
            begin
                repeat (30) tick();
                #2 S_AXI_ARESETN = 1'b0;
                #1;
                checks++; if ({rx_busy, rx_if.rx_valid, rx_if.rx_count, rx_if.rx_data} !== 13'b0) begin failures++; $display("FAIL rst_mid busy_valid_count_data got=%b exp=0", {rx_busy, rx_if.rx_valid, rx_if.rx_count, rx_if.rx_data}); end
            end
        join
        S_AXI_ARESETN = 1'b1;
        repeat (10) tick();
        checks++; if ({rx_busy, rx_if.rx_valid} !== 2'b00) begin failures++; $display("FAIL rst_after got=%b exp=00", {rx_busy, rx_if.rx_valid}); end
    endtask

    task automatic test_baud_change();
        baud_div = 16'd7;
        fork
            send_frame(8'hC3, 1'b1, 8);
            begin
                repeat (30) tick();
                baud_div = 16'd15;
            end
        join
        checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'hC3}) begin failures++; $display("FAIL baud_old valid_data got=%h exp=1c3", {rx_if.rx_valid, rx_if.rx_data}); end
        do_pop();
        send_frame(8'h3A, 1'b1, 16);
        checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'h3A}) begin failures++; $display("FAIL baud_new valid_data got=%h exp=13a", {rx_if.rx_valid, rx_if.rx_data}); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL baud_new_ferr got=%b exp=0", frame_err); end
        do_pop();
        baud_div = 16'd7;
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        test_baud_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
